// File: rtl/powlib_pkg.sv
// Shared helpers for the powlib arbiter slice.
// Provides the source-index width derivation and the arbiter FSM state encoding.
package powlib_pkg;

  typedef enum logic {
    ARB = 1'b0,
    PKT = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A single requester still needs a 1-bit source field.
  function automatic int src_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/powlib_rrsel.sv
// Combinational rotating-priority selector: lowest requester at or after ptr wins, wrapping.
// Zero latency; no state and no backpressure of its own.
module powlib_rrsel
  import powlib_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [src_w(N)-1:0]   ptr,
  output logic [N-1:0]          gnt,
  output logic [src_w(N)-1:0]   idx,
  output logic                  any
);

  localparam int SW = src_w(N);

  logic [2*N-1:0] w_req2;
  logic [2*N-1:0] w_mask;
  logic [2*N-1:0] w_hit;

  // Upper copy of the request vector stands in for requesters 0..ptr-1 after wrap.
  always_comb begin
    w_req2 = {req, req};
    w_mask = '0;
    for (int j = 0; j < 2 * N; j++) begin
      w_mask[j] = (j >= int'(ptr));
    end
    w_hit = w_req2 & w_mask;
  end

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int j = 2 * N - 1; j >= 0; j--) begin
      if (w_hit[j]) begin
        any = 1'b1;
        idx = SW'((j >= N) ? j - N : j);
        gnt = '0;
        gnt[(j >= N) ? j - N : j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/powlib_rrarb.sv
// Round-robin arbiter feeding one registered output stage; packets keep ownership until last beat.
// One cycle from transfer to out_vld; in_rdy is withheld whenever the output register cannot load.
module powlib_rrarb
  import powlib_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N*W-1:0]        in_dat,
  input  logic [N-1:0]          in_vld,
  input  logic [N-1:0]          in_lst,
  output logic [N-1:0]          in_rdy,
  output logic [W-1:0]          out_dat,
  output logic [src_w(N)-1:0]   out_src,
  output logic                  out_lst,
  output logic                  out_vld,
  input  logic                  out_rdy
);

  localparam int SW = src_w(N);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_ptr;
  logic [SW-1:0] w_ptr_nxt;
  logic [SW-1:0] r_own;
  logic [SW-1:0] w_own_nxt;

  logic [W-1:0]  r_dat;
  logic [SW-1:0] r_src;
  logic          r_lst;
  logic          r_vld;

  logic [N-1:0]  w_req;
  logic [N-1:0]  w_gnt;
  logic [SW-1:0] w_idx;
  logic [SW-1:0] w_idx_inc;
  logic          w_any;
  logic          w_ld;
  logic          w_xfer;
  logic [W-1:0]  w_dat;
  logic          w_lst;

  assign w_ld = !r_vld || out_rdy;

  // While a packet is open only the owner may be selected.
  always_comb begin
    w_req = in_vld;
    if (r_state == PKT) begin
      w_req        = '0;
      w_req[r_own] = in_vld[r_own];
    end
  end

  powlib_rrsel #(.N(N)) u_sel (
    .req (w_req),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  assign w_xfer    = rst && w_ld && w_any;
  assign in_rdy    = w_xfer ? w_gnt : '0;
  assign w_idx_inc = (w_idx == SW'(N - 1)) ? '0 : w_idx + SW'(1);

  always_comb begin
    w_dat = '0;
    w_lst = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        w_dat = in_dat[i*W +: W];
        w_lst = in_lst[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_own_nxt   = r_own;
    if (w_xfer) begin
      if (!w_lst) begin
        w_state_nxt = PKT;
        w_own_nxt   = w_idx;
      end else begin
        w_state_nxt = ARB;
        w_ptr_nxt   = w_idx_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB;
      r_ptr   <= '0;
      r_own   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_own   <= w_own_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
      r_src <= '0;
      r_lst <= 1'b0;
    end else if (w_xfer) begin
      r_vld <= 1'b1;
      r_dat <= w_dat;
      r_src <= w_idx;
      r_lst <= w_lst;
    end else if (w_ld) begin
      r_vld <= 1'b0;
    end
  end

  assign out_dat = r_dat;
  assign out_src = r_src;
  assign out_lst = r_lst;
  assign out_vld = r_vld;

endmodule

// File: tb/tb_powlib_rrarb.sv
// Scoreboard bench for powlib_rrarb: per-requester beat queues drive the inputs,
// expected output beats are queued up front and checked by a forked monitor.
module tb_powlib_rrarb;

  logic        clk;
  logic        rst;
  logic [63:0] in_dat;
  logic [3:0]  in_vld;
  logic [3:0]  in_lst;
  logic [3:0]  in_rdy;
  logic [15:0] out_dat;
  logic [1:0]  out_src;
  logic        out_lst;
  logic        out_vld;
  logic        out_rdy;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] q_dat [4][$];
  logic        q_lst [4][$];
  logic [18:0] exp_q [$];

  powlib_rrarb #(.N(4), .W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_dat  (in_dat),
    .in_vld  (in_vld),
    .in_lst  (in_lst),
    .in_rdy  (in_rdy),
    .out_dat (out_dat),
    .out_src (out_src),
    .out_lst (out_lst),
    .out_vld (out_vld),
    .out_rdy (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic add_beat(input int i, input logic [15:0] d, input logic l);
    q_dat[i].push_back(d);
    q_lst[i].push_back(l);
  endtask

  task automatic expect_beat(input int src, input logic [15:0] d, input logic l);
    exp_q.push_back({2'(src), d, l});
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      in_vld[i]         = (q_dat[i].size() != 0);
      in_dat[i*16 +: 16] = (q_dat[i].size() != 0) ? q_dat[i][0] : 16'h0000;
      in_lst[i]         = (q_lst[i].size() != 0) ? q_lst[i][0] : 1'b0;
    end
  endtask

  // Handshake is sampled mid-cycle; accepted beats retire right after the edge.
  task automatic cycle();
    logic [3:0] acc;
    @(negedge clk);
    acc = in_vld & in_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        void'(q_dat[i].pop_front());
        void'(q_lst[i].pop_front());
      end
    end
    refresh();
  endtask

  task automatic run_until_done(input string nm, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cycle();
      k++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic monitor();
    logic [18:0] e;
    forever begin
      @(negedge clk);
      if (rst && out_vld && out_rdy) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_beat: unexpected beat src=%0d dat=%h lst=%b", out_src, out_dat, out_lst);
        end else begin
          e = exp_q.pop_front();
          if ({out_src, out_dat, out_lst} !== e) begin
            n_err++;
            $display("FAIL out_beat: got src=%0d dat=%h lst=%b, expected src=%0d dat=%h lst=%b",
                     out_src, out_dat, out_lst, e[18:17], e[16:1], e[0]);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    out_rdy = 1'b1;
    in_vld  = '0;
    in_dat  = '0;
    in_lst  = '0;
    fork
      monitor();
    join_none

    // Reset hold with every requester valid, then fairness sweep.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        add_beat(i, 16'(16'h00A0 + i), 1'b1);
        expect_beat(i, 16'(16'h00A0 + i), 1'b1);
      end
    end
    refresh();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_dat", out_dat, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_out_lst", out_lst, 0);
    rst = 1'b1;
    repeat (8) cycle();
    @(negedge clk);
    #1;
    chk("fair_rate", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Backpressure: beat from requester 1 held while requester 2 waits.
    out_rdy = 1'b0;
    add_beat(1, 16'h1234, 1'b1);
    add_beat(2, 16'h5678, 1'b1);
    expect_beat(1, 16'h1234, 1'b1);
    expect_beat(2, 16'h5678, 1'b1);
    refresh();
    cycle();
    chk("bp_out_vld", out_vld, 1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_out_dat", out_dat, 32'h1234);
      chk("bp_out_src", out_src, 1);
      chk("bp_out_lst", out_lst, 1);
      chk("bp_in_rdy", in_rdy, 0);
    end
    out_rdy = 1'b1;
    run_until_done("bp_drain", 10);

    // Packet lock: requester 1 three beats, requester 2 waiting (ptr=3 here).
    add_beat(1, 16'h1B00, 1'b0);
    add_beat(1, 16'h1B01, 1'b0);
    add_beat(1, 16'h1B02, 1'b1);
    add_beat(2, 16'h2C00, 1'b1);
    expect_beat(1, 16'h1B00, 1'b0);
    expect_beat(1, 16'h1B01, 1'b0);
    expect_beat(1, 16'h1B02, 1'b1);
    expect_beat(2, 16'h2C00, 1'b1);
    refresh();
    run_until_done("pkt_drain", 12);

    // ptr=3 after requester 2: 3 wins over 0.
    add_beat(0, 16'hD000, 1'b1);
    add_beat(3, 16'hD003, 1'b1);
    expect_beat(3, 16'hD003, 1'b1);
    expect_beat(0, 16'hD000, 1'b1);
    refresh();
    run_until_done("ptr3_drain", 8);

    // Sparse: only requester 3, then 0 and 3 after ptr wraps to 0.
    add_beat(3, 16'h3D00, 1'b1);
    add_beat(3, 16'h3D01, 1'b1);
    add_beat(3, 16'h3D02, 1'b1);
    expect_beat(3, 16'h3D00, 1'b1);
    expect_beat(3, 16'h3D01, 1'b1);
    expect_beat(3, 16'h3D02, 1'b1);
    refresh();
    run_until_done("sparse_drain", 10);
    add_beat(0, 16'h0E00, 1'b1);
    add_beat(3, 16'h0E03, 1'b1);
    expect_beat(0, 16'h0E00, 1'b1);
    expect_beat(3, 16'h0E03, 1'b1);
    refresh();
    run_until_done("wrap_drain", 8);

    // Reset in the middle of a packet owned by requester 2.
    out_rdy = 1'b0;
    add_beat(2, 16'hE200, 1'b0);
    add_beat(2, 16'hE201, 1'b0);
    refresh();
    cycle();
    chk("mid_pre_vld", out_vld, 1);
    chk("mid_pre_src", out_src, 2);
    rst = 1'b0;
    #1;
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_src", out_src, 0);
    chk("mid_rst_in_rdy", in_rdy, 0);
    for (int i = 0; i < 4; i++) begin
      q_dat[i].delete();
      q_lst[i].delete();
    end
    refresh();
    cycle();
    rst = 1'b1;
    add_beat(0, 16'hF000, 1'b1);
    add_beat(2, 16'hF002, 1'b1);
    expect_beat(0, 16'hF000, 1'b1);
    expect_beat(2, 16'hF002, 1'b1);
    refresh();
    out_rdy = 1'b1;
    run_until_done("mid_drain", 8);

    repeat (2) cycle();
    chk("idle_out_vld", out_vld, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
